// File: rtl/spoon_decode_sequencer_pkg.sv
// Shared definitions for the sparse-matrix decode sequencer: FSM state
// encodings and default job parameters.
package spoon_decode_sequencer_pkg;

  // Default decoder value-RAM depth in 64-bit words.
  localparam int DICT_MAX_DEF     = 256;
  // Minimum cycles between packet-word handshakes.
  localparam int PACE_DEF         = 3;
  // Idle cycles after the last packet push before done.
  localparam int DRAIN_CYCLES_DEF = 4;

  // FSM state encodings.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_DICT  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_PKT   = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;

endpackage

// File: rtl/spoon_pace_counter.sv
// Packet pacing counter: loaded with PACE-1 on each packet handshake and
// counting down to zero, so the decoder's stall flag has caught up with
// every earlier push before the next word is accepted.
module spoon_pace_counter
  import spoon_decode_sequencer_pkg::*;
#(
  parameter int PACE = PACE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic ready
);

  localparam logic [1:0] LOAD_VAL = 2'(PACE - 1);

  logic [1:0] pace_cnt;

  // Reload on handshake, otherwise count down and hold at zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pace_cnt <= 2'd0;
    end else if (load) begin
      pace_cnt <= LOAD_VAL;
    end else if (pace_cnt != 2'd0) begin
      pace_cnt <= pace_cnt - 2'd1;
    end
  end

  assign ready = (pace_cnt == 2'd0);

endmodule

// File: rtl/spoon_decode_sequencer.sv
// Job-level controller in front of the sparse-matrix packet decoder:
// clears the decoder, loads the value dictionary (ram-in mode), then
// streams paced packet words (push mode) and signals done after a drain.
module spoon_decode_sequencer
  import spoon_decode_sequencer_pkg::*;
#(
  parameter int DICT_MAX     = DICT_MAX_DEF,
  parameter int PACE         = PACE_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_dict_words,
  input  logic [31:0] cmd_pkt_words,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        dec_reset,
  output logic [63:0] dec_data,
  output logic        dec_push,
  output logic        dec_ram_in,
  input  logic        dec_stall,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [8:0] DICT_MAX_W = 9'(DICT_MAX);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [8:0]  dict_cnt;
  logic [31:0] pkt_cnt;
  logic        clear_cnt;
  logic [2:0]  drain_cnt;
  logic        pace_ready;
  logic        in_hs;
  logic        cmd_bad;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign cmd_bad   = (cmd_dict_words > DICT_MAX_W);
  assign in_hs     = in_valid & in_ready;

  spoon_pace_counter #(.PACE(PACE)) u_pace (
    .clk   (clk),
    .reset (reset),
    .load  ((state == ST_PKT) && in_hs),
    .ready (pace_ready)
  );

  // Source stream acceptance: always in DICT, paced and stall-gated in PKT.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_DICT: in_ready = 1'b1;
      ST_PKT:  in_ready = !dec_stall && pace_ready;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state decode for the job sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid && !cmd_bad) state_nxt = ST_CLEAR;
      ST_CLEAR: if (clear_cnt) begin
                  if (dict_cnt != 9'd0)      state_nxt = ST_DICT;
                  else if (pkt_cnt != 32'd0) state_nxt = ST_PKT;
                  else                       state_nxt = ST_DRAIN;
                end
      ST_DICT:  if (in_hs && dict_cnt == 9'd1) state_nxt = ST_GAP;
      ST_GAP:   state_nxt = (pkt_cnt != 32'd0) ? ST_PKT : ST_DRAIN;
      ST_PKT:   if (in_hs && pkt_cnt == 32'd1) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == 3'd0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State, job counters and registered decoder-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      dict_cnt   <= 9'd0;
      pkt_cnt    <= 32'd0;
      clear_cnt  <= 1'b0;
      drain_cnt  <= 3'd0;
      dec_reset  <= 1'b1;
      dec_data   <= 64'd0;
      dec_push   <= 1'b0;
      dec_ram_in <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      // Decoder reset tracks the CLEAR state cycle-for-cycle.
      dec_reset  <= (state_nxt == ST_CLEAR);
      dec_push   <= 1'b0;
      dec_ram_in <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      clear_cnt  <= (state == ST_CLEAR) && !clear_cnt;

      if (state_nxt == ST_DRAIN && state != ST_DRAIN) begin
        drain_cnt <= DRAIN_LOAD;
      end else if (state == ST_DRAIN && drain_cnt != 3'd0) begin
        drain_cnt <= drain_cnt - 3'd1;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_bad) begin
              err <= 1'b1;
            end else begin
              dict_cnt <= cmd_dict_words;
              pkt_cnt  <= cmd_pkt_words;
            end
          end
        end
        ST_DICT: begin
          if (in_hs) begin
            dec_data   <= in_data;
            dec_ram_in <= 1'b1;
            dict_cnt   <= dict_cnt - 9'd1;
          end
        end
        ST_PKT: begin
          if (in_hs) begin
            dec_data <= in_data;
            dec_push <= 1'b1;
            pkt_cnt  <= pkt_cnt - 32'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 3'd0) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spoon_decode_sequencer.sv
// Directed self-checking bench for spoon_decode_sequencer. Sample index k
// counts clock edges after the edge that accepts the command (k=0 is the
// first cycle in CLEAR); outputs are sampled 1 time unit after each edge.
module tb_spoon_decode_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_dict_words;
  logic [31:0] cmd_pkt_words;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        dec_reset;
  logic [63:0] dec_data;
  logic        dec_push;
  logic        dec_ram_in;
  logic        dec_stall;
  logic        busy;
  logic        done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-job observations.
  int          push_cyc[$];
  int          ram_cyc[$];
  logic [63:0] push_data[$];
  logic [63:0] ram_data[$];
  logic        rdy_hist[0:511];
  int          done_cyc;
  int          rst_cnt;
  int          hs_cnt;
  int          word_idx;
  logic        busy0;

  spoon_decode_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_dict_words (cmd_dict_words),
    .cmd_pkt_words  (cmd_pkt_words),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .dec_reset      (dec_reset),
    .dec_data       (dec_data),
    .dec_push       (dec_push),
    .dec_ram_in     (dec_ram_in),
    .dec_stall      (dec_stall),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [63:0] dget(input logic [63:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return '1;
  endfunction

  // Issue one command and observe the job until done, the cycle budget
  // runs out, or (abort_at>0) that many pushes have been seen.
  task automatic run_job(input logic [8:0] dw, input logic [31:0] pw,
                         input int stall_at, input int stall_len, input int abort_at);
    int   stall_left;
    logic hs;
    stall_left = 0;
    push_cyc.delete(); ram_cyc.delete(); push_data.delete(); ram_data.delete();
    for (int i = 0; i < 512; i++) rdy_hist[i] = 1'b0;
    done_cyc = -1; rst_cnt = 0; hs_cnt = 0; word_idx = 0;
    in_data = 64'd0; in_valid = 1'b1; dec_stall = 1'b0;
    cmd_dict_words = dw; cmd_pkt_words = pw; cmd_valid = 1'b1;
    #1;
    check("cmd_ready_before_job", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    busy0 = busy;
    for (int k = 0; k < 512; k++) begin
      if (dec_reset)  rst_cnt++;
      if (dec_ram_in) begin ram_cyc.push_back(k);  ram_data.push_back(dec_data);  end
      if (dec_push)   begin push_cyc.push_back(k); push_data.push_back(dec_data); end
      if (done) begin done_cyc = k; break; end
      if (abort_at != 0 && push_cyc.size() == abort_at) return;
      if (stall_at != 0 && dec_push && push_cyc.size() == stall_at) stall_left = stall_len;
      dec_stall = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      #1;
      hs = in_valid & in_ready;
      rdy_hist[k] = in_ready;
      @(posedge clk); #1;
      if (hs) begin
        hs_cnt++;
        word_idx++;
        in_data = 64'(word_idx);
      end
    end
    in_valid  = 1'b0;
    dec_stall = 1'b0;
  endtask

  initial begin
    int ev;
    int act;
    reset = 1'b1; cmd_valid = 1'b0; cmd_dict_words = '0; cmd_pkt_words = '0;
    in_data = '0; in_valid = 1'b0; dec_stall = 1'b0;
    #12;
    // Reset state.
    check("rst_cmd_ready",  {63'd0, cmd_ready},  64'd1);
    check("rst_in_ready",   {63'd0, in_ready},   64'd0);
    check("rst_dec_reset",  {63'd0, dec_reset},  64'd1);
    check("rst_dec_push",   {63'd0, dec_push},   64'd0);
    check("rst_dec_ram_in", {63'd0, dec_ram_in}, 64'd0);
    check("rst_dec_data",   dec_data,            64'd0);
    check("rst_busy",       {63'd0, busy},       64'd0);
    check("rst_done_err",   {62'd0, done, err},  64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_dec_reset_low", {63'd0, dec_reset}, 64'd0);

    // Dictionary only: dict=3, pkt=0.
    run_job(9'd3, 32'd0, 0, 0, 0);
    check("d3_busy",       {63'd0, busy0}, 64'd1);
    check("d3_rst_cycles", 64'(rst_cnt), 64'd2);
    check("d3_ram_count",  64'(ram_cyc.size()), 64'd3);
    check("d3_ram_first",  64'(qget(ram_cyc, 0)), 64'd3);
    check("d3_ram_last",   64'(qget(ram_cyc, 2)), 64'd5);
    for (int i = 0; i < 3; i++) check($sformatf("d3_ram_data%0d", i), dget(ram_data, i), 64'(i));
    check("d3_push_count", 64'(push_cyc.size()), 64'd0);
    check("d3_gap_in_ready", {63'd0, rdy_hist[5]}, 64'd0);
    check("d3_done_cycle", 64'(done_cyc), 64'd10);

    // Packets only: dict=0, pkt=6, no stall.
    run_job(9'd0, 32'd6, 0, 0, 0);
    check("p6_push_count", 64'(push_cyc.size()), 64'd6);
    for (int i = 0; i < 6; i++) check($sformatf("p6_push_cyc%0d", i), 64'(qget(push_cyc, i)), 64'(3 + 3 * i));
    check("p6_last_data",  dget(push_data, 5), 64'd5);
    check("p6_ram_count",  64'(ram_cyc.size()), 64'd0);
    check("p6_hs_count",   64'(hs_cnt), 64'd6);
    check("p6_done_cycle", 64'(done_cyc), 64'd22);

    // Stall for 10 cycles after the 2nd push: dict=0, pkt=4.
    run_job(9'd0, 32'd4, 2, 10, 0);
    ev = 0;
    for (int k = 6; k < 16; k++) if (rdy_hist[k]) ev++;
    check("st_ready_while_stalled", 64'(ev), 64'd0);
    check("st_push2_cyc", 64'(qget(push_cyc, 1)), 64'd6);
    check("st_push3_cyc", 64'(qget(push_cyc, 2)), 64'd17);
    check("st_push4_cyc", 64'(qget(push_cyc, 3)), 64'd20);
    check("st_done_cycle", 64'(done_cyc), 64'd24);

    // Rejected command: dict=300.
    cmd_dict_words = 9'd300; cmd_pkt_words = 32'd5; cmd_valid = 1'b1;
    #1;
    check("err_cmd_ready_offer", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("err_pulse",     {63'd0, err},       64'd1);
    check("err_busy",      {63'd0, busy},      64'd0);
    check("err_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    ev = 0; act = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (err) ev++;
      if (busy || dec_reset || dec_push || dec_ram_in || !cmd_ready) act++;
    end
    check("err_single_pulse", 64'(ev), 64'd0);
    check("err_no_activity",  64'(act), 64'd0);

    // Empty job: dict=0, pkt=0.
    run_job(9'd0, 32'd0, 0, 0, 0);
    check("e0_rst_cycles", 64'(rst_cnt), 64'd2);
    check("e0_hs_count",   64'(hs_cnt), 64'd0);
    check("e0_push_ram",   64'(push_cyc.size() + ram_cyc.size()), 64'd0);
    check("e0_done_cycle", 64'(done_cyc), 64'd6);

    // Boundary: dict=DICT_MAX is accepted, then one packet.
    run_job(9'd256, 32'd1, 0, 0, 0);
    check("dmax_ram_count", 64'(ram_cyc.size()), 64'd256);
    check("dmax_ram_last",  dget(ram_data, 255), 64'd255);
    check("dmax_push_cyc",  64'(qget(push_cyc, 0)), 64'd260);
    check("dmax_push_data", dget(push_data, 0), 64'd256);
    check("dmax_done_cycle", 64'(done_cyc), 64'd264);

    // Asynchronous reset mid-PKT after 2 of 5 words.
    run_job(9'd0, 32'd5, 0, 0, 2);
    check("ab_push_seen", {63'd0, dec_push}, 64'd1);
    reset = 1'b1;
    #1;
    check("ab_busy",      {63'd0, busy},      64'd0);
    check("ab_dec_push",  {63'd0, dec_push},  64'd0);
    check("ab_dec_reset", {63'd0, dec_reset}, 64'd1);
    check("ab_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("ab_in_ready",  {63'd0, in_ready},  64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Clean job after the abort: dict=2, pkt=2.
    run_job(9'd2, 32'd2, 0, 0, 0);
    check("cj_ram_first",  64'(qget(ram_cyc, 0)), 64'd3);
    check("cj_ram_data1",  dget(ram_data, 1), 64'd1);
    check("cj_push_cyc0",  64'(qget(push_cyc, 0)), 64'd6);
    check("cj_push_cyc1",  64'(qget(push_cyc, 1)), 64'd9);
    check("cj_push_data1", dget(push_data, 1), 64'd3);
    check("cj_done_cycle", 64'(done_cyc), 64'd13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spoon_decode_sequencer.md
Name: spoon_decode_sequencer

Overview:
- Job-level controller in front of the sparse-matrix packet decoder.
- Accepts one command per matrix slice and clears the decoder. Streams the value-dictionary words into the decoder's value RAM (ram-in mode), then streams packet words (push mode).
- Paces packet pushes so the decoder's 32-byte buffer never overflows. Signals completion after a drain window.
- Sits between the memory-read stream and the decoder.

Parameters:
- DICT_MAX, 256, capacity of the decoder value RAM in 64-bit words.
- PACE, 3, minimum cycles between packet-word handshakes (covers the 2-cycle push-to-count latency).
- DRAIN_CYCLES, 4, idle cycles after the last packet push before done.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted (high only in IDLE)
- cmd_dict_words  in  9  dictionary words, 0..DICT_MAX
- cmd_pkt_words  in  32  packet words, 0 allowed
- in_data  in  64  source stream word
- in_valid  in  1  source word valid
- in_ready  out  1  word consumed when in_valid & in_ready
- dec_reset  out  1  decoder synchronous reset
- dec_data  out  64  decoder data
- dec_push  out  1  decoder push_in
- dec_ram_in  out  1  decoder ramIn
- dec_stall  in  1  decoder stall
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  one-cycle pulse on rejected command

Behaviour:
- Reset state: IDLE, cmd_ready=1, in_ready=0, dec_reset=1, dec_push=0, dec_ram_in=0, dec_data=0, busy=0, done=0, err=0.
- Register dependencies: all dec_* outputs and done/err are registered. cmd_ready and in_ready are combinational from state, counters and pacing.
- IDLE: on cmd_valid:
  - If cmd_dict_words > DICT_MAX: pulse err next cycle and stay in IDLE.
  - Otherwise latch both counts, go to CLEAR, busy=1.
- CLEAR: dec_reset=1 for 2 cycles. This clears decoder byte count, row/column and RAM write pointer. Then:
  - To DICT if dict>0.
  - Else to PKT if pkt>0.
  - Else to DRAIN.
- DICT:
  - in_ready=1. Each handshake registers dec_data=in_data, dec_ram_in=1, dec_push=0, and decrements the dict count.
  - dec_stall is ignored in DICT.
  - After the last word, go to GAP.
- GAP: 1 cycle with dec_ram_in=0, so the decoder's RAM address mux returns to the read path before packets arrive. Then go to PKT, or to DRAIN if pkt=0.
- PKT:
  - in_ready = !dec_stall AND pace_cnt==0.
  - Each handshake registers dec_data=in_data, dec_push=1, dec_ram_in=0, loads pace_cnt=PACE-1, and decrements the pkt count.
  - pace_cnt decrements to 0 each cycle.
  - Non-handshake cycles drive dec_push=0.
  - After the last word, go to DRAIN.
  - Pacing guarantee: with PACE≥3 every earlier push is reflected in dec_stall, so buffer occupancy ≤ 15+8 bytes.
- DRAIN: counts DRAIN_CYCLES; in_ready=0. Then pulse done, busy=0, go to IDLE.
- in_valid low in DICT/PKT: wait indefinitely, no timeout.
- Async reset mid-job: return to IDLE immediately. dec_reset is asserted by the reset value, so the decoder is cleared on the next clock.
- Counters: dict count 9 bits, pkt count 32 bits, pace count 2 bits, drain count 3 bits; none wrap.

Decomposition:
- Shared package: state enumeration (IDLE, CLEAR, DICT, GAP, PKT, DRAIN) and the DICT_MAX/PACE defaults.
- One natural sub-module: spoon_pace_counter, which loads PACE-1, counts down, and gates in_ready.

Test Plan:
- Command dict=3, pkt=0; in_valid always high -> dec_ram_in high 3 consecutive cycles with data words 0..2; done pulses 2+3+1+4 cycles after the CLEAR entry edge; in_ready=0 in GAP.
- Command dict=0, pkt=6, dec_stall=0 -> exactly one handshake every 3 cycles, 6 dec_push pulses, dec_ram_in never high, done after DRAIN.
- Command pkt=4; force dec_stall=1 for 10 cycles after the 2nd push -> no handshakes while stalled; 3rd push occurs 1 cycle after the first registered cycle with dec_stall low.
- Command dict_words=300 -> err pulses once, cmd_ready stays 1, busy stays 0, no dec_* activity.
- Assert reset during PKT after 2 of 5 words -> IDLE immediately, busy=0, dec_push=0, dec_reset=1; a new job then runs cleanly.
- Command dict=0, pkt=0 -> 2 cycles of dec_reset, 4 drain cycles, done pulse, zero handshakes.
